// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scanout fetch has priority, and the CPU port is guaranteed a slot by a fairness streak.
// Optional build macro VRAM_ARB_STARVE_EN adds the video wait counter and a sticky vid_starve_o flag.
module vram_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 16,
  parameter int CPU_FAIR  = 4,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 vid_req_i,
  input  logic [ADDR_BITS-1:0] vid_addr_i,
  output logic                 vid_ack_o,
  output logic [DATA_BITS-1:0] vid_data_o,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_BITS-1:0] cpu_addr_i,
  input  logic [DATA_BITS-1:0] cpu_wdata_i,
  output logic                 cpu_ack_o,
  output logic [DATA_BITS-1:0] cpu_rdata_o,
  output logic [ADDR_BITS-1:0] ram_addr_o,
  output logic                 ram_we_o,
  output logic [DATA_BITS-1:0] ram_wdata_o,
  input  logic [DATA_BITS-1:0] ram_rdata_i,
  output logic                 vid_starve_o
);

  typedef enum logic [2:0] {IDLE, V_ADDR, V_DATA, C_ADDR, C_DATA} state_e;

  localparam int            SW   = (CPU_FAIR < 1) ? 1 : $clog2(CPU_FAIR + 1);
  localparam logic [SW-1:0] FAIR = SW'(CPU_FAIR);

  if (CPU_FAIR < 0 || MAX_WAIT < 0) begin : g_bad_params
    $error("vram_arbiter: CPU_FAIR and MAX_WAIT must be non-negative");
  end

  state_e                 state_q, state_d;
  logic [SW-1:0]          streak_q, streak_d;
  logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic                   ram_we_q, ram_we_d;
  logic [DATA_BITS-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_BITS-1:0]   vid_data_q, vid_data_d;
  logic [DATA_BITS-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                   vid_ack_q, vid_ack_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic                   cpu_grant, vid_grant;

  // The CPU only beats a simultaneous video request once the video streak has reached CPU_FAIR.
  assign cpu_grant = (state_q == IDLE) && cpu_req_i && (!vid_req_i || streak_q == FAIR);
  assign vid_grant = (state_q == IDLE) && vid_req_i && !cpu_grant;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    streak_d    = streak_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          state_d    = C_ADDR;
          streak_d   = '0;
          ram_addr_d = cpu_addr_i;
          if (cpu_we_i) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = cpu_wdata_i;
          end
        end else if (vid_grant) begin
          state_d    = V_ADDR;
          ram_addr_d = vid_addr_i;
          if (!cpu_req_i) begin
            streak_d = '0;
          end else if (streak_q != FAIR) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      V_ADDR: state_d = V_DATA;
      V_DATA: begin
        state_d    = IDLE;
        vid_data_d = ram_rdata_i;
        vid_ack_d  = 1'b1;
      end
      C_ADDR: begin
        // A write retires here; the registered write strobe marks which kind of access this is.
        if (ram_we_q) begin
          state_d   = IDLE;
          cpu_ack_d = 1'b1;
        end else begin
          state_d = C_DATA;
        end
      end
      C_DATA: begin
        state_d     = IDLE;
        cpu_rdata_d = ram_rdata_i;
        cpu_ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign vid_ack_o   = vid_ack_q;
  assign vid_data_o  = vid_data_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;

`ifdef VRAM_ARB_STARVE_EN
  localparam int            WW       = $clog2(MAX_WAIT + 2);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT + 1);

  logic [WW-1:0] wait_q, wait_d;
  logic          starve_q, starve_d;
  logic          vid_busy;

  assign vid_busy = (state_q == V_ADDR) || (state_q == V_DATA);

  // Saturating one past MAX_WAIT is enough to remember that the limit was exceeded.
  always_comb begin
    wait_d = wait_q;
    if (vid_grant) begin
      wait_d = '0;
    end else if (vid_req_i && !vid_busy && wait_q != WAIT_SAT) begin
      wait_d = wait_q + WW'(1);
    end
    starve_d = starve_q || (wait_d > WW'(MAX_WAIT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign vid_starve_o = starve_q;
`else
  assign vid_starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int FAIR = 4;
  localparam int MAXW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_req, cpu_req, cpu_we;
  logic [AW-1:0] vid_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          vid_ack, cpu_ack, ram_we, vid_starve;
  logic [DW-1:0] vid_data, cpu_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;

  logic          f0_vid_ack, f0_cpu_ack, f0_ram_we, f0_starve;
  logic [DW-1:0] f0_vid_data, f0_cpu_rdata, f0_ram_wdata;
  logic [AW-1:0] f0_ram_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .CPU_FAIR(FAIR), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_i(rst),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(vid_ack), .vid_data_o(vid_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .vid_starve_o(vid_starve)
  );

  // Second instance with CPU_FAIR=0: the CPU must win every contended arbitration.
  vram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .CPU_FAIR(0), .MAX_WAIT(MAXW)) dut_f0 (
    .clk_i(clk), .rst_i(rst),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(f0_vid_ack), .vid_data_o(f0_vid_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(f0_cpu_ack), .cpu_rdata_o(f0_cpu_rdata),
    .ram_addr_o(f0_ram_addr), .ram_we_o(f0_ram_we), .ram_wdata_o(f0_ram_wdata), .ram_rdata_i(16'h0000),
    .vid_starve_o(f0_starve)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 12'h010) return 16'hBEEF;
    if (a == 12'h031) return 16'hA5C3;
    return {a[3:0], ~a};
  endfunction

  // Synchronous-read VRAM: data for the address presented at one edge appears after the next edge.
  logic [DW-1:0] ram_mem [0:4095];
  bit            ram_wr  [0:4095];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum {OWN_V, OWN_CR, OWN_CW} own_e;
  own_e          m_owner = OWN_V;
  int            m_busy = 0, m_streak = 0, m_wait = 0;
  bit            m_started = 1'b0;
  logic [AW-1:0] m_addr = '0, m_ram_addr = '0;
  logic          m_vid_ack = 1'b0, m_cpu_ack = 1'b0, m_ram_we = 1'b0, m_starve = 1'b0;
  logic [DW-1:0] m_ram_wdata = '0, m_vid_data = '0, m_cpu_rdata = '0;
  logic [DW-1:0] ref_mem [0:4095];
  bit            ref_wr  [0:4095];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin : model
    bit vid_active, vid_won;
    vid_active = (m_busy > 0) && (m_owner == OWN_V);
    vid_won    = 1'b0;
    m_vid_ack  = 1'b0;
    m_cpu_ack  = 1'b0;
    m_ram_we   = 1'b0;
    if (rst) begin
      m_busy = 0; m_streak = 0; m_wait = 0; m_starve = 1'b0;
      m_ram_addr = '0; m_ram_wdata = '0; m_vid_data = '0; m_cpu_rdata = '0;
      m_started = 1'b1;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_owner == OWN_V) begin
          m_vid_ack  = 1'b1;
          m_vid_data = ref_read(m_addr);
        end else begin
          m_cpu_ack = 1'b1;
          if (m_owner == OWN_CR) m_cpu_rdata = ref_read(m_addr);
        end
      end
    end else if (cpu_req && (!vid_req || m_streak == FAIR)) begin
      m_owner = cpu_we ? OWN_CW : OWN_CR;
      m_addr = cpu_addr; m_ram_addr = cpu_addr; m_streak = 0;
      if (cpu_we) begin
        m_busy = 1; m_ram_we = 1'b1; m_ram_wdata = cpu_wdata;
        ref_mem[cpu_addr] = cpu_wdata; ref_wr[cpu_addr] = 1'b1;
      end else begin
        m_busy = 2;
      end
    end else if (vid_req) begin
      vid_won = 1'b1; m_owner = OWN_V; m_busy = 2;
      m_addr = vid_addr; m_ram_addr = vid_addr;
      m_streak = !cpu_req ? 0 : (m_streak < FAIR ? m_streak + 1 : FAIR);
    end
    if (!rst) begin
      if (vid_won) m_wait = 0;
      else if (vid_req && !vid_active && m_wait < MAXW + 1) m_wait++;
`ifdef VRAM_ARB_STARVE_EN
      if (m_wait > MAXW) m_starve = 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("vid_ack", vid_ack, m_vid_ack);
      check("cpu_ack", cpu_ack, m_cpu_ack);
      check("ram_we", ram_we, m_ram_we);
      check("ram_addr", ram_addr, m_ram_addr);
      check("ram_wdata", ram_wdata, m_ram_wdata);
      check("vid_data", vid_data, m_vid_data);
      check("cpu_rdata", cpu_rdata, m_cpu_rdata);
      check("vid_starve", vid_starve, m_starve);
    end
  end

  // ---------------- directed and random stimulus ----------------
  task automatic wait_ack(input bit is_cpu, input int max_cyc, output int lat, output bit we_seen);
    lat = -1;
    we_seen = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (ram_we) we_seen = 1'b1;
      if ((is_cpu ? cpu_ack : vid_ack) === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  initial begin
    int       lat, nseq, v_between, n_vid, n_cpu, f0_v, f0_c;
    bit       we_seen;
    logic [9:0] seq;

    vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_vid_ack", vid_ack, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_vid_starve", vid_starve, 0);
    rst = 1'b0;
    @(negedge clk);

    // Video read of 0x010
    vid_req = 1'b1; vid_addr = 12'h010;
    wait_ack(1'b0, 10, lat, we_seen);
    vid_req = 1'b0;
    check("t1_vid_latency", lat, 3);
    check("t1_vid_data", vid_data, 16'hBEEF);
    check("t1_ram_we_quiet", we_seen, 0);
    repeat (2) @(negedge clk);

    // CPU write 0x1234 to 0x020, then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'h1234;
    @(negedge clk);
    check("t2_ram_we", ram_we, 1);
    check("t2_ram_addr", ram_addr, 12'h020);
    check("t2_ram_wdata", ram_wdata, 16'h1234);
    wait_ack(1'b1, 10, lat, we_seen);
    check("t2_wr_latency", lat + 1, 2);
    check("t2_ram_we_one_cycle", ram_we, 0);
    cpu_we = 1'b0;
    wait_ack(1'b1, 10, lat, we_seen);
    cpu_req = 1'b0;
    check("t2_rd_latency", lat, 3);
    check("t2_readback", cpu_rdata, 16'h1234);
    repeat (2) @(negedge clk);

    // Both requests held: V,V,V,V,C repeating; CPU_FAIR=0 instance serves only the CPU
    vid_req = 1'b1; vid_addr = 12'h005; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h006;
    seq = '0; nseq = 0; v_between = 0; n_vid = 0; n_cpu = 0; f0_v = 0; f0_c = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (f0_vid_ack) f0_v++;
      if (f0_cpu_ack) f0_c++;
      if (vid_ack) begin
        n_vid++; v_between++;
        if (nseq < 10) begin seq = {seq[8:0], 1'b0}; nseq++; end
      end
      if (cpu_ack) begin
        n_cpu++;
        check("t3_vid_acks_between_cpu", v_between, 4);
        v_between = 0;
        if (nseq < 10) begin seq = {seq[8:0], 1'b1}; nseq++; end
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("t3_grant_order", seq, 10'b0000100001);
    check("t3_vid_ack_count", n_vid, 16);
    check("t3_cpu_ack_count", n_cpu, 4);
    check("t3_fair0_vid_acks", f0_v, 0);
    check("t3_fair0_cpu_acks", f0_c, 20);
`ifdef VRAM_ARB_STARVE_EN
    check("t3_starve_set", vid_starve, 1);
`else
    check("t3_starve_off", vid_starve, 0);
`endif
    repeat (3) @(negedge clk);

    // CPU read alone, video arrives one cycle later and waits for it
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 12'h031;
    wait_ack(1'b1, 10, lat, we_seen);
    cpu_req = 1'b0;
    check("t4_cpu_latency", lat + 1, 3);
    check("t4_cpu_rdata", cpu_rdata, 16'h0FCF);
    wait_ack(1'b0, 10, lat, we_seen);
    vid_req = 1'b0;
    check("t4_vid_after_cpu", lat, 3);
    check("t4_vid_data", vid_data, 16'hA5C3);
`ifdef VRAM_ARB_STARVE_EN
    check("t4_starve_sticky", vid_starve, 1);
`endif
    repeat (2) @(negedge clk);

    // Reset during V_DATA aborts the fetch
    vid_req = 1'b1; vid_addr = 12'h040;
    repeat (2) @(negedge clk);
    rst = 1'b1; vid_req = 1'b0;
    @(negedge clk);
    check("t5_no_vid_ack", vid_ack, 0);
    check("t5_ram_addr", ram_addr, 0);
    check("t5_vid_data", vid_data, 0);
    check("t5_cpu_rdata", cpu_rdata, 0);
    check("t5_vid_starve", vid_starve, 0);
    rst = 1'b0;
    @(negedge clk);
    vid_req = 1'b1;
    wait_ack(1'b0, 10, lat, we_seen);
    vid_req = 1'b0;
    check("t5_retry_latency", lat, 3);
    check("t5_retry_data", vid_data, 16'h0FBF);
    repeat (2) @(negedge clk);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(199, 0) == 0);
      if (vid_req && vid_ack) begin
        if ($urandom_range(1, 0) == 0) vid_req = 1'b0;
        else vid_addr = AW'($urandom_range(63, 0));
      end else if (!vid_req && $urandom_range(2, 0) == 0) begin
        vid_req = 1'b1; vid_addr = AW'($urandom_range(63, 0));
      end
      if (cpu_req && cpu_ack) begin
        if ($urandom_range(1, 0) == 0) cpu_req = 1'b0;
        else begin
          cpu_we = 1'($urandom_range(1, 0)); cpu_addr = AW'($urandom_range(63, 0)); cpu_wdata = DW'($urandom);
        end
      end else if (!cpu_req && $urandom_range(2, 0) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(1, 0));
        cpu_addr = AW'($urandom_range(63, 0)); cpu_wdata = DW'($urandom);
      end
    end
    rst = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
